// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter that shares the TX async-FIFO write port between the ALU (two bytes) and RegFile (one byte).
// Define TX_ARB_STALL_CNT_EN to add the saturating STALL_CNT output.
module tx_fifo_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ALU_REQ,
    input  logic [2*DATA_WIDTH-1:0]   ALU_DATA,
    output logic                      ALU_ACK,
    input  logic                      REG_REQ,
    input  logic [DATA_WIDTH-1:0]     REG_DATA,
    output logic                      REG_ACK,
    input  logic                      FIFO_FULL,
    output logic                      FIFO_WR_INC,
    output logic [DATA_WIDTH-1:0]     FIFO_WR_DATA,
`ifdef TX_ARB_STALL_CNT_EN
    output logic [CNT_WIDTH-1:0]      STALL_CNT,
`endif
    output logic                      BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALU_LO = 2'd1,
        ALU_HI = 2'd2,
        REG_B  = 2'd3
    } state_t;

    state_t                    state_q;
    logic [2*DATA_WIDTH-1:0]   hold_q;
    logic                      last_alu_q;
    logic                      alu_ack_q;
    logic                      reg_ack_q;
    logic                      wr_inc_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic                      busy_q;

    logic                      grant_alu_d;
    logic                      grant_reg_d;
    logic                      can_write_d;

    // When both request, the side that was not granted last wins.
    always_comb begin
        grant_alu_d = ALU_REQ && (!REG_REQ || !last_alu_q);
        grant_reg_d = REG_REQ && (!ALU_REQ ||  last_alu_q);
        // Skipping the cycle after a strobe lets FIFO_FULL reflect that write.
        can_write_d = !FIFO_FULL && !wr_inc_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            last_alu_q <= 1'b0;
            alu_ack_q  <= 1'b0;
            reg_ack_q  <= 1'b0;
            wr_inc_q   <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            alu_ack_q <= 1'b0;
            reg_ack_q <= 1'b0;
            wr_inc_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_alu_d) begin
                        hold_q     <= ALU_DATA;
                        last_alu_q <= 1'b1;
                        alu_ack_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ALU_LO;
                    end else if (grant_reg_d) begin
                        hold_q     <= {{DATA_WIDTH{1'b0}}, REG_DATA};
                        last_alu_q <= 1'b0;
                        reg_ack_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= REG_B;
                    end
                end
                ALU_LO: begin
                    if (can_write_d) begin
                        wr_inc_q  <= 1'b1;
                        wr_data_q <= hold_q[DATA_WIDTH-1:0];
                        state_q   <= ALU_HI;
                    end
                end
                ALU_HI: begin
                    if (can_write_d) begin
                        wr_inc_q  <= 1'b1;
                        wr_data_q <= hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                REG_B: begin
                    if (can_write_d) begin
                        wr_inc_q  <= 1'b1;
                        wr_data_q <= hold_q[DATA_WIDTH-1:0];
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TX_ARB_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (state_q != IDLE && FIFO_FULL && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

    assign ALU_ACK      = alu_ack_q;
    assign REG_ACK      = reg_ack_q;
    assign FIFO_WR_INC  = wr_inc_q;
    assign FIFO_WR_DATA = wr_data_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed self-checking bench for tx_fifo_arbiter; stall-counter checks run when TX_ARB_STALL_CNT_EN is defined.
module tb_tx_fifo_arbiter;

    localparam int DW = 8;
`ifdef TX_ARB_STALL_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            ALU_REQ = 1'b0;
    logic [2*DW-1:0] ALU_DATA = '0;
    logic            ALU_ACK;
    logic            REG_REQ = 1'b0;
    logic [DW-1:0]   REG_DATA = '0;
    logic            REG_ACK;
    logic            FIFO_FULL = 1'b0;
    logic            FIFO_WR_INC;
    logic [DW-1:0]   FIFO_WR_DATA;
    logic            BUSY;
`ifdef TX_ARB_STALL_CNT_EN
    logic [CW-1:0]   STALL_CNT;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 CLK = ~CLK;

    tx_fifo_arbiter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ALU_REQ      (ALU_REQ),
        .ALU_DATA     (ALU_DATA),
        .ALU_ACK      (ALU_ACK),
        .REG_REQ      (REG_REQ),
        .REG_DATA     (REG_DATA),
        .REG_ACK      (REG_ACK),
        .FIFO_FULL    (FIFO_FULL),
        .FIFO_WR_INC  (FIFO_WR_INC),
        .FIFO_WR_DATA (FIFO_WR_DATA),
`ifdef TX_ARB_STALL_CNT_EN
        .STALL_CNT    (STALL_CNT),
`endif
        .BUSY         (BUSY)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Advance one cycle; inputs driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    // One cycle of outputs: ack pair, strobe, busy.
    task automatic expect_cyc(input string tag, input logic aa, input logic ra,
                              input logic wi, input logic by);
        check_eq({tag, ".alu_ack"}, ALU_ACK, aa);
        check_eq({tag, ".reg_ack"}, REG_ACK, ra);
        check_eq({tag, ".wr_inc"},  FIFO_WR_INC, wi);
        check_eq({tag, ".busy"},    BUSY, by);
    endtask

    initial begin
        // reset state
        do_reset();
        expect_cyc("rst", 0, 0, 0, 0);
        check_eq("rst.wr_data", FIFO_WR_DATA, 8'h00);
`ifdef TX_ARB_STALL_CNT_EN
        check_eq("rst.stall", STALL_CNT, 0);
`endif

        // 1: ALU alone, no backpressure
        ALU_REQ = 1'b1; ALU_DATA = 16'h12C4;
        step(); expect_cyc("t1.c1", 1, 0, 0, 1); ALU_REQ = 1'b0;
        step(); expect_cyc("t1.c2", 0, 0, 1, 1); check_eq("t1.lo", FIFO_WR_DATA, 8'hC4);
        step(); expect_cyc("t1.c3", 0, 0, 0, 1);
        step(); expect_cyc("t1.c4", 0, 0, 1, 0); check_eq("t1.hi", FIFO_WR_DATA, 8'h12);
        step(); expect_cyc("t1.c5", 0, 0, 0, 0);

        // 2: RegFile alone
        REG_REQ = 1'b1; REG_DATA = 8'h5A;
        step(); expect_cyc("t2.c1", 0, 1, 0, 1); REG_REQ = 1'b0;
        step(); expect_cyc("t2.c2", 0, 0, 1, 0); check_eq("t2.byte", FIFO_WR_DATA, 8'h5A);
        step(); expect_cyc("t2.c3", 0, 0, 0, 0); check_eq("t2.hold", FIFO_WR_DATA, 8'h5A);
        step(); expect_cyc("t2.c4", 0, 0, 0, 0);

        // 3a: both after reset -> ALU first (last_grant resets to REG), then REG
        do_reset();
        ALU_REQ = 1'b1; ALU_DATA = 16'hBEEF; REG_REQ = 1'b1; REG_DATA = 8'h33;
        step(); expect_cyc("t3a.c1", 1, 0, 0, 1); ALU_REQ = 1'b0;
        step(); expect_cyc("t3a.c2", 0, 0, 1, 1); check_eq("t3a.lo", FIFO_WR_DATA, 8'hEF);
        step(); expect_cyc("t3a.c3", 0, 0, 0, 1);
        step(); expect_cyc("t3a.c4", 0, 0, 1, 0); check_eq("t3a.hi", FIFO_WR_DATA, 8'hBE);
        step(); expect_cyc("t3a.c5", 0, 1, 0, 1); REG_REQ = 1'b0;
        step(); expect_cyc("t3a.c6", 0, 0, 1, 0); check_eq("t3a.reg", FIFO_WR_DATA, 8'h33);

        // 3b: ALU granted last -> next contention goes to REG, then ALU
        ALU_REQ = 1'b1; ALU_DATA = 16'h0102;
        step(); ALU_REQ = 1'b0;
        step(); step(); step();
        check_eq("t3b.pre_hi", FIFO_WR_DATA, 8'h01);
        ALU_REQ = 1'b1; ALU_DATA = 16'hCAFE; REG_REQ = 1'b1; REG_DATA = 8'h77;
        step(); expect_cyc("t3b.c1", 0, 1, 0, 1); REG_REQ = 1'b0;
        step(); expect_cyc("t3b.c2", 0, 0, 1, 0); check_eq("t3b.reg", FIFO_WR_DATA, 8'h77);
        step(); expect_cyc("t3b.c3", 1, 0, 0, 1); ALU_REQ = 1'b0;
        step(); expect_cyc("t3b.c4", 0, 0, 1, 1); check_eq("t3b.lo", FIFO_WR_DATA, 8'hFE);
        step();
        step(); expect_cyc("t3b.c6", 0, 0, 1, 0); check_eq("t3b.hi", FIFO_WR_DATA, 8'hCA);

        // 4: FIFO full for 5 cycles between LO and HI
        do_reset();
        ALU_REQ = 1'b1; ALU_DATA = 16'hA55A;
        step(); ALU_REQ = 1'b0;
        step(); expect_cyc("t4.lo", 0, 0, 1, 1); check_eq("t4.lo_d", FIFO_WR_DATA, 8'h5A);
        step();
        FIFO_FULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("t4.stall_wr", FIFO_WR_INC, 1'b0);
            check_eq("t4.stall_busy", BUSY, 1'b1);
            check_eq("t4.stall_data", FIFO_WR_DATA, 8'h5A);
            step();
        end
        FIFO_FULL = 1'b0;
        expect_cyc("t4.c8", 0, 0, 0, 1);
        step(); expect_cyc("t4.c9", 0, 0, 1, 0); check_eq("t4.hi", FIFO_WR_DATA, 8'hA5);
`ifdef TX_ARB_STALL_CNT_EN
        check_eq("t4.stall_cnt", STALL_CNT, 5);
`endif
        step(); expect_cyc("t4.c10", 0, 0, 0, 0);

        // 5: reset while in ALU_HI, then REG re-arbitrated
        do_reset();
        ALU_REQ = 1'b1; ALU_DATA = 16'h7788;
        step(); ALU_REQ = 1'b0;
        step(); check_eq("t5.lo", FIFO_WR_DATA, 8'h88);
        step();
        RST = 1'b1; REG_REQ = 1'b1; REG_DATA = 8'h66;
        step(); expect_cyc("t5.rst", 0, 0, 0, 0); check_eq("t5.rst_data", FIFO_WR_DATA, 8'h00);
        RST = 1'b0;
        step(); expect_cyc("t5.c1", 0, 1, 0, 1); REG_REQ = 1'b0;
        step(); expect_cyc("t5.c2", 0, 0, 1, 0); check_eq("t5.reg", FIFO_WR_DATA, 8'h66);

        // 6: grant while full, 20 stalled cycles in REG_B
        do_reset();
        FIFO_FULL = 1'b1; REG_REQ = 1'b1; REG_DATA = 8'h11;
        step(); expect_cyc("t6.c1", 0, 1, 0, 1); REG_REQ = 1'b0;
        for (int i = 0; i < 19; i++) step();
        expect_cyc("t6.c20", 0, 0, 0, 1);
`ifdef TX_ARB_STALL_CNT_EN
        check_eq("t6.stall_pre", STALL_CNT, 4'hF);
`endif
        step();
        FIFO_FULL = 1'b0;
`ifdef TX_ARB_STALL_CNT_EN
        check_eq("t6.stall_sat", STALL_CNT, 4'hF);
`endif
        expect_cyc("t6.c21", 0, 0, 0, 1);
        step(); expect_cyc("t6.c22", 0, 0, 1, 0); check_eq("t6.byte", FIFO_WR_DATA, 8'h11);
`ifdef TX_ARB_STALL_CNT_EN
        check_eq("t6.stall_hold", STALL_CNT, 4'hF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
